board_frame_writer: RTL and testbench
=====================================

# board_frame_writer

Renders the Mastermind board into the SDRAM frame buffer that the LCD timing controller scans out. One 800x480 frame is generated per start request, in raster order, as 16-bit word pairs in the same packing the display path reads back. Backpressure comes from the SDRAM write FIFO. It sits between the game-state logic, which holds guess and peg memory, and the SDRAM controller write port.

## Interface
- H_ACTIVE, 800: pixels per line
- V_ACTIVE, 480: lines per frame
- CELL_W, 100: width of one game-row column (x)
- CELL_H, 96: height of one peg slot (y)
- R_BIG, 40: guess-peg radius; inside when dx²+dy² < R_BIG²
- R_KEY, 10: key-peg radius
- iCLK  in  1  pixel/system clock
- iRST_n  in  1  reset, asynchronous, active-low
- iSTART  in  1  one-cycle pulse; begin a frame
- iNUM_ROWS  in  4  game rows played, 0..8, sampled on accepted iSTART
- oROW_ADDR  out  3  row-memory read address
- iROW_DATA  in  18  row word, valid 1 cycle after oROW_ADDR: [2:0]..[11:9] slot0..3 colour code, [14:12] black count, [17:15] white count
- oFRAME_START  out  1  one-cycle pulse; SDRAM controller resets write address
- oWR_REQ  out  1  write word valid
- iWR_FULL  in  1  FIFO full; word not accepted while high
- oWR_DATA1  out  16  {R[7:0], G[7:0]}
- oWR_DATA2  out  16  {8'h00, B[7:0]}
- oBUSY  out  1  high from accepted iSTART until oDONE
- oDONE  out  1  one-cycle pulse after the last word is accepted

## Operation
- States: IDLE, LOAD, DRAW, DONE.
- IDLE:
  - On iSTART, latch iNUM_ROWS, pulse oFRAME_START, go to LOAD.
  - iSTART in any other state is ignored.
- LOAD:
  - Issue oROW_ADDR 0..7 on consecutive cycles.
  - Capture iROW_DATA one cycle later into an 8-entry register file.
  - Rows with index >= latched iNUM_ROWS are stored as all-zero.
  - Go to DRAW after the 8th capture.
- DRAW:
  - Counters: x 0..799 and y 0..479, plus sub-counters cx 0..99 with col 0..7, and cy 0..95 with slot 0..4 (slot 4 = key strip). No dividers.
  - Counters advance only on an accepted word (oWR_REQ & !iWR_FULL).
  - oWR_REQ and data are held stable while iWR_FULL is high.
- Pixel colour, first match wins:
  - Slot 0..3: if (cx-50)²+(cy-48)² < 1600 and code of slot in row col is 1..6, use that colour. Codes: 1 FF0000, 2 00FF00, 3 0000FF, 4 FFA500, 5 800080, 6 FFFF00.
  - Slot 4: key peg k = 0..3 centred at (cx = 20+20k, cy = 48), inside when d² < 100. Peg k is black 000000 if k < black; else white FFFFFF if k < black+white; else background.
  - Otherwise background 404040.
- Codes 0 and 7 render as background.
- black+white > 4 is clipped naturally, since only 4 pegs are drawn.
- Arithmetic: dx, dy are signed 8-bit; squares are unsigned 13-bit; sum is 14-bit, compared unsigned.
- DONE: oDONE high one cycle, oBUSY low, return to IDLE.
- Reset (any time, including mid-frame):
  - State goes to IDLE; all counters and the register file clear.
  - oWR_REQ, oFRAME_START, oBUSY and oDONE go to 0; oROW_ADDR to 0; data outputs to 0.
  - A partially written frame is abandoned.

## Timing
- iSTART accepted at cycle 0. oFRAME_START and oBUSY are high at cycle 1.
- oROW_ADDR = 0..7 at cycles 1..8; captures at cycles 2..9.
- First oWR_REQ at cycle 10, pixel (0,0).
- Without backpressure, one word per cycle:
  - last word (799,479) at cycle 384009;
  - oDONE at cycle 384010, with oBUSY low the same cycle.
- Each cycle of iWR_FULL high adds exactly one cycle of latency.
- Colour for the presented pixel is registered: data changes only on the cycle after acceptance.
- oWR_REQ stays high continuously through DRAW, including under iWR_FULL.

## Test plan
- iNUM_ROWS=0, iSTART, no backpressure -> 384000 words, all 404040; oFRAME_START at cycle 1; oDONE at cycle 384010.
- Row 0 = {white 0, black 0, slots 1,2,3,6}, iNUM_ROWS=1:
  - pixel (50,48) -> FF0000; (50,144) -> 00FF00; (50,240) -> 0000FF; (50,336) -> FFFF00.
  - (50,8), where d²=1600, -> 404040.
  - (150,48), row 1 unplayed, -> 404040.
- Row 2 with black=1, white=2:
  - (220,432) -> 000000; (240,432) and (260,432) -> FFFFFF; (280,432) -> 404040.
- Random iWR_FULL at 50% -> word sequence identical to the no-backpressure run; data held while full; no word duplicated or dropped.
- iSTART repeated during DRAW -> ignored, frame count unchanged. Reset asserted at word 1000 -> all outputs 0 immediately; next iSTART yields a full correct frame.
- iNUM_ROWS=5 with garbage in rows 5..7 -> x >= 500 renders background only.

Source files
------------

// File: rtl/board_frame_writer.sv
// Renders the Mastermind board, one raster frame per start request, into the SDRAM write FIFO.
// The geometry parameters must satisfy H_ACTIVE = 8*CELL_W and V_ACTIVE = 5*CELL_H.
module board_frame_writer #(
    parameter int H_ACTIVE = 800,
    parameter int V_ACTIVE = 480,
    parameter int CELL_W   = 100,
    parameter int CELL_H   = 96,
    parameter int R_BIG    = 40,
    parameter int R_KEY    = 10
) (
    input  logic        iCLK,
    input  logic        iRST_n,
    input  logic        iSTART,
    input  logic [3:0]  iNUM_ROWS,
    output logic [2:0]  oROW_ADDR,
    input  logic [17:0] iROW_DATA,
    output logic        oFRAME_START,
    output logic        oWR_REQ,
    input  logic        iWR_FULL,
    output logic [15:0] oWR_DATA1,
    output logic [15:0] oWR_DATA2,
    output logic        oBUSY,
    output logic        oDONE
);
    localparam int KP = CELL_W / 5;
    localparam logic [13:0] RB2 = 14'(R_BIG * R_BIG);
    localparam logic [13:0] RK2 = 14'(R_KEY * R_KEY);
    localparam logic [23:0] BG  = 24'h404040;

    typedef enum logic [1:0] {IDLE, LOAD, DRAW, DONE} state_t;
    state_t state, stateNxt;

    logic [3:0]       numRows, loadCnt;
    logic [2:0]       capIdx;
    logic [7:0][17:0] rowFile;
    logic             frameStartQ, lastQ, step, atEnd;
    logic [23:0]      rgbQ, pixRgb;

    // x/y counters always point at the next pixel to be loaded into rgbQ
    logic [9:0] x, xN;
    logic [8:0] y, yN;
    logic [6:0] cx, cxN, cy, cyN;
    logic [2:0] col, colN, slot, slotN;

    function automatic logic [12:0] sq13(input logic signed [7:0] d);
        logic signed [15:0] e, p;
        e = {{8{d[7]}}, d};
        p = e * e;
        return p[12:0];
    endfunction

    function automatic logic [23:0] codeRgb(input logic [2:0] c);
        case (c)
            3'd1:    return 24'hFF0000;
            3'd2:    return 24'h00FF00;
            3'd3:    return 24'h0000FF;
            3'd4:    return 24'hFFA500;
            3'd5:    return 24'h800080;
            3'd6:    return 24'hFFFF00;
            default: return BG;
        endcase
    endfunction

    assign capIdx = loadCnt[2:0] - 3'd1;
    assign atEnd  = (x == 10'(H_ACTIVE - 1)) && (y == 9'(V_ACTIVE - 1));
    assign step   = ((state == LOAD) && (loadCnt == 4'd8)) ||
                    ((state == DRAW) && !iWR_FULL && !lastQ);

    always_comb begin
        xN = x + 10'd1; yN = y; cxN = cx + 7'd1; cyN = cy; colN = col; slotN = slot;
        if (cx == 7'(CELL_W - 1)) begin
            cxN = '0; colN = col + 3'd1;
        end
        if (x == 10'(H_ACTIVE - 1)) begin
            xN = '0; cxN = '0; colN = '0; yN = y + 9'd1; cyN = cy + 7'd1;
            if (cy == 7'(CELL_H - 1)) begin
                cyN = '0; slotN = slot + 3'd1;
            end
            if (y == 9'(V_ACTIVE - 1)) begin
                yN = '0; cyN = '0; slotN = '0;
            end
        end
    end

    // Colour of the look-ahead pixel; first match wins
    always_comb begin
        logic [17:0]        rowW;
        logic [2:0]         code, black, white;
        logic signed [7:0]  dx, dy, kdx;
        logic [13:0]        d2;
        logic               hit;
        rowW   = rowFile[col];
        black  = rowW[14:12];
        white  = rowW[17:15];
        dx     = 8'(cx) - 8'(CELL_W / 2);
        dy     = 8'(cy) - 8'(CELL_H / 2);
        d2     = {1'b0, sq13(dx)} + {1'b0, sq13(dy)};
        pixRgb = BG;
        hit    = 1'b0;
        kdx    = '0;
        case (slot)
            3'd0:    code = rowW[2:0];
            3'd1:    code = rowW[5:3];
            3'd2:    code = rowW[8:6];
            3'd3:    code = rowW[11:9];
            default: code = 3'd0;
        endcase
        if (slot < 3'd4) begin
            if (d2 < RB2) pixRgb = codeRgb(code);
        end else begin
            for (int k = 0; k < 4; k++) begin
                kdx = 8'(cx) - 8'((k + 1) * KP);
                if (!hit && (({1'b0, sq13(kdx)} + {1'b0, sq13(dy)}) < RK2)) begin
                    hit = 1'b1;
                    if (4'(k) < {1'b0, black})
                        pixRgb = 24'h000000;
                    else if (4'(k) < ({1'b0, black} + {1'b0, white}))
                        pixRgb = 24'hFFFFFF;
                end
            end
        end
    end

    always_comb begin
        stateNxt = state;
        case (state)
            IDLE: if (iSTART) stateNxt = LOAD;
            LOAD: if (loadCnt == 4'd8) stateNxt = DRAW;
            DRAW: if (!iWR_FULL && lastQ) stateNxt = DONE;
            DONE: stateNxt = IDLE;
            default: stateNxt = IDLE;
        endcase
    end

    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            state <= IDLE;
            numRows <= '0; loadCnt <= '0; rowFile <= '0;
            frameStartQ <= 1'b0; lastQ <= 1'b0; rgbQ <= '0;
            x <= '0; y <= '0; cx <= '0; cy <= '0; col <= '0; slot <= '0;
        end else begin
            state       <= stateNxt;
            frameStartQ <= (state == IDLE) && iSTART;
            if ((state == IDLE) && iSTART) begin
                numRows <= iNUM_ROWS; loadCnt <= '0; lastQ <= 1'b0;
                x <= '0; y <= '0; cx <= '0; cy <= '0; col <= '0; slot <= '0;
            end
            if (state == LOAD) begin
                loadCnt <= loadCnt + 4'd1;
                // Unplayed rows are forced to zero so stale memory never shows
                if (loadCnt != 4'd0)
                    rowFile[capIdx] <= ({1'b0, capIdx} < numRows) ? iROW_DATA : '0;
            end
            if (step) begin
                rgbQ  <= pixRgb;
                lastQ <= atEnd;
                x <= xN; y <= yN; cx <= cxN; cy <= cyN; col <= colN; slot <= slotN;
            end
        end
    end

    assign oROW_ADDR    = (state == LOAD) ? loadCnt[2:0] : 3'd0;
    assign oFRAME_START = frameStartQ;
    assign oWR_REQ      = (state == DRAW);
    assign oBUSY        = (state == LOAD) || (state == DRAW);
    assign oDONE        = (state == DONE);
    assign oWR_DATA1    = rgbQ[23:8];
    assign oWR_DATA2    = {8'h00, rgbQ[7:0]};
endmodule

// File: tb/tb_board_frame_writer.sv
// Scoreboard bench for board_frame_writer on a reduced board (20x16 cells) to keep frames short.
module tb_board_frame_writer;
    localparam int CW = 20, CH = 16, HA = CW * 8, VA = CH * 5, RB = 8, RK = 2;
    localparam int NPIX = HA * VA;
    localparam logic [23:0] BG = 24'h404040;

    logic        iCLK = 1'b0, iRST_n = 1'b0, iSTART = 1'b0, iWR_FULL = 1'b0;
    logic [3:0]  iNUM_ROWS = '0;
    logic [17:0] iROW_DATA = '0;
    logic [2:0]  oROW_ADDR;
    logic        oFRAME_START, oWR_REQ, oBUSY, oDONE;
    logic [15:0] oWR_DATA1, oWR_DATA2;

    board_frame_writer #(.H_ACTIVE(HA), .V_ACTIVE(VA), .CELL_W(CW), .CELL_H(CH),
                         .R_BIG(RB), .R_KEY(RK)) dut (
        .iCLK(iCLK), .iRST_n(iRST_n), .iSTART(iSTART), .iNUM_ROWS(iNUM_ROWS),
        .oROW_ADDR(oROW_ADDR), .iROW_DATA(iROW_DATA), .oFRAME_START(oFRAME_START),
        .oWR_REQ(oWR_REQ), .iWR_FULL(iWR_FULL), .oWR_DATA1(oWR_DATA1),
        .oWR_DATA2(oWR_DATA2), .oBUSY(oBUSY), .oDONE(oDONE));

    always #5 iCLK = ~iCLK;

    logic [17:0] rowMem [8];
    always @(posedge iCLK) iROW_DATA <= rowMem[oROW_ADDR];

    int checks = 0, errors = 0;
    int wordCnt = 0, fsCount = 0, fsExp = 0, nRowsRef = 0;
    bit bpEn = 1'b0, heldPend = 1'b0;
    logic [31:0] heldData;
    logic [23:0] expQ [$];
    logic [23:0] fb [NPIX];

    task automatic chk(input string nm, input logic [47:0] act, input logic [47:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [23:0] lut(input int c);
        case (c)
            1: return 24'hFF0000;  2: return 24'h00FF00;  3: return 24'h0000FF;
            4: return 24'hFFA500;  5: return 24'h800080;  6: return 24'hFFFF00;
            default: return BG;
        endcase
    endfunction

    // Reference: plain division/modulo geometry straight from the board layout rules
    function automatic logic [23:0] refPix(input int px, input int py);
        int col, cx, slot, cy, code, dx, dy, blk, wht, kx, r;
        col = px / CW; cx = px % CW; slot = py / CH; cy = py % CH;
        r = (col < nRowsRef) ? int'(rowMem[col]) : 0;
        dy = cy - CH / 2;
        if (slot < 4) begin
            code = (r >> (3 * slot)) & 7;
            dx = cx - CW / 2;
            if (dx * dx + dy * dy < RB * RB && code >= 1 && code <= 6) return lut(code);
        end else begin
            blk = (r >> 12) & 7;
            wht = (r >> 15) & 7;
            for (int k = 0; k < 4; k++) begin
                kx = cx - (k + 1) * (CW / 5);
                if (kx * kx + dy * dy < RK * RK) begin
                    if (k < blk) return 24'h000000;
                    if (k < blk + wht) return 24'hFFFFFF;
                    return BG;
                end
            end
        end
        return BG;
    endfunction

    initial forever begin
        @(posedge iCLK);
        #1 iWR_FULL = bpEn ? 1'($urandom_range(0, 1)) : 1'b0;
    end

    // Monitor: pops one expected pixel per accepted word
    always @(negedge iCLK) begin
        logic [23:0] e;
        if (iRST_n) begin
            if (oFRAME_START) fsCount++;
            if (heldPend)
                chk("hold_while_full", {15'd0, oWR_REQ, oWR_DATA1, oWR_DATA2}, {15'd0, 1'b1, heldData});
            heldPend = oWR_REQ && iWR_FULL;
            heldData = {oWR_DATA1, oWR_DATA2};
            if (oWR_REQ && !iWR_FULL) begin
                if (expQ.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL extra_word: got word %0d expected none", wordCnt);
                end else begin
                    e = expQ.pop_front();
                    chk($sformatf("pixel(%0d,%0d)", wordCnt % HA, wordCnt / HA),
                        {16'd0, oWR_DATA1, oWR_DATA2}, {16'd0, e[23:8], 8'h00, e[7:0]});
                end
                if (wordCnt < NPIX) fb[wordCnt] = {oWR_DATA1, oWR_DATA2[7:0]};
                wordCnt++;
            end
        end else heldPend = 1'b0;
    end

    task automatic runFrame(input int nRows, input int dupStartCyc, input int rstWord);
        int cyc, first, stalls;
        bit done;
        expQ.delete();
        wordCnt = 0; nRowsRef = nRows; fsExp++;
        for (int py = 0; py < VA; py++)
            for (int px = 0; px < HA; px++) expQ.push_back(refPix(px, py));
        @(negedge iCLK); iNUM_ROWS = 4'(nRows); iSTART = 1'b1;
        @(negedge iCLK); iSTART = 1'b0; cyc = 1;
        chk("frame_start_c1", 48'(oFRAME_START), 48'd1);
        chk("busy_c1", 48'(oBUSY), 48'd1);
        chk("row_addr_c1", 48'(oROW_ADDR), 48'd0);
        first = -1; stalls = 0; done = 1'b0;
        while (!done && cyc < 4 * NPIX + 100) begin
            @(negedge iCLK); cyc++;
            iSTART = (cyc == dupStartCyc);
            if (cyc == 2) chk("frame_start_c2", 48'(oFRAME_START), 48'd0);
            if (oWR_REQ && first < 0) first = cyc;
            if (oWR_REQ && iWR_FULL) stalls++;
            if (rstWord >= 0 && wordCnt >= rstWord) begin
                iRST_n = 1'b0; iSTART = 1'b0;
                #1;
                chk("outputs_in_reset", {18'd0, oROW_ADDR, oFRAME_START, oWR_REQ, oBUSY, oDONE,
                    oWR_DATA1, oWR_DATA2}, 48'd0);
                expQ.delete();
                repeat (2) @(negedge iCLK);
                iRST_n = 1'b1;
                return;
            end
            if (oDONE) done = 1'b1;
        end
        if (!done) begin
            checks++; errors++;
            $display("FAIL done_timeout: got no oDONE after %0d cycles expected cycle %0d", cyc, 10 + NPIX + stalls);
        end
        chk("first_req_cycle", 48'(first), 48'd10);
        chk("done_cycle", 48'(cyc), 48'(10 + NPIX + stalls));
        chk("busy_at_done", 48'(oBUSY), 48'd0);
        @(negedge iCLK);
        chk("done_one_cycle", 48'(oDONE), 48'd0);
        chk("words_left", 48'(expQ.size()), 48'd0);
        chk("word_count", 48'(wordCnt), 48'(NPIX));
        chk("frame_count", 48'(fsCount), 48'(fsExp));
    endtask

    function automatic logic [23:0] fbAt(input int px, input int py);
        return fb[py * HA + px];
    endfunction

    initial begin
        int bad;
        for (int i = 0; i < 8; i++) rowMem[i] = 18'($urandom);
        repeat (3) @(negedge iCLK);
        chk("reset_state", {18'd0, oROW_ADDR, oFRAME_START, oWR_REQ, oBUSY, oDONE,
            oWR_DATA1, oWR_DATA2}, 48'd0);
        iRST_n = 1'b1;
        repeat (2) @(negedge iCLK);

        // No rows played: whole frame background
        runFrame(0, -1, -1);
        bad = 0;
        for (int i = 0; i < NPIX; i++) if (fb[i] !== BG) bad++;
        chk("empty_board_bg", 48'(bad), 48'd0);

        // Row 0 slots 1,2,3,6; row 1 loaded but not played
        rowMem[0] = {3'd0, 3'd0, 3'd6, 3'd3, 3'd2, 3'd1};
        rowMem[1] = {15'($urandom), 3'd1};
        rowMem[2] = {3'd2, 3'd1, 12'($urandom)};
        rowMem[3] = {3'd4, 3'd3, 12'($urandom)};
        runFrame(1, -1, -1);
        chk("slot0_red",    48'(fbAt(CW/2, CH/2)),          48'hFF0000);
        chk("slot1_green",  48'(fbAt(CW/2, CH + CH/2)),     48'h00FF00);
        chk("slot2_blue",   48'(fbAt(CW/2, 2*CH + CH/2)),   48'h0000FF);
        chk("slot3_yellow", 48'(fbAt(CW/2, 3*CH + CH/2)),   48'hFFFF00);
        chk("rim_d2_eq_r2", 48'(fbAt(CW/2, 0)),             48'(BG));
        chk("row1_unplayed",48'(fbAt(CW + CW/2, CH/2)),     48'(BG));

        // Key pegs, oversized black+white, 50% backpressure, ignored restart
        bpEn = 1'b1;
        runFrame(4, 500, -1);
        chk("key0_black", 48'(fbAt(2*CW + CW/5,   4*CH + CH/2)), 48'h000000);
        chk("key1_white", 48'(fbAt(2*CW + 2*CW/5, 4*CH + CH/2)), 48'hFFFFFF);
        chk("key2_white", 48'(fbAt(2*CW + 3*CW/5, 4*CH + CH/2)), 48'hFFFFFF);
        chk("key3_bg",    48'(fbAt(2*CW + 4*CW/5, 4*CH + CH/2)), 48'(BG));
        chk("key_clip",   48'(fbAt(3*CW + 4*CW/5, 4*CH + CH/2)), 48'hFFFFFF);

        // Reset mid-frame, then a fresh frame with garbage in unplayed rows
        for (int i = 0; i < 8; i++) rowMem[i] = 18'($urandom);
        runFrame(8, -1, 1000);
        for (int i = 0; i < 8; i++) rowMem[i] = 18'($urandom) | 18'h00249;
        bpEn = 1'b0;
        runFrame(5, -1, -1);
        bad = 0;
        for (int py = 0; py < VA; py++)
            for (int px = 5 * CW; px < HA; px++) if (fbAt(px, py) !== BG) bad++;
        chk("unplayed_cols_bg", 48'(bad), 48'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
